// File: rtl/palette_lut.sv
// palette_lut: palette RAM lookup and colour output stage.
// A single-port 2^IDX_W x 16 palette RAM (two byte banks) is shared between
// the pixel fetch, which always wins on a ce_pix cycle, and a req/ack CPU port.
// Optional build macro PAL_HIGHLIGHT_EN adds the pix_highlight input.
// cpu_state is a debug view of the CPU access FSM (0 IDLE, 1 ACCESS, 2 ACK, 3 WAIT).
module palette_lut #(
    parameter int IDX_W       = 11,
    parameter int OUT_W       = 6,   // 5..8
    parameter int SHADOW_MODE = 0    // 0: E>>1, 1: E-(E>>2)
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic [IDX_W-1:0] pix_idx,
    input  logic             pix_blank_n,
    input  logic             pix_shadow,
`ifdef PAL_HIGHLIGHT_EN
    input  logic             pix_highlight,
`endif
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [IDX_W-1:0] cpu_addr,
    input  logic [1:0]       cpu_be,
    input  logic [15:0]      cpu_din,
    output logic [15:0]      cpu_dout,
    output logic             cpu_ack,
    output logic [OUT_W-1:0] red,
    output logic [OUT_W-1:0] green,
    output logic [OUT_W-1:0] blue,
    output logic             pix_valid,
    output logic [1:0]       cpu_state
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [OUT_W-1:0] OUT_MAX = {OUT_W{1'b1}};

    // CPU handshake: the CPU raises cpu_req (with we/addr/be/din stable) and
    // holds it; cpu_ack pulses for one cycle when the access is done and
    // cpu_dout is valid during that pulse. A new access is only accepted
    // after cpu_req has been seen low, so a held request is served once.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2,
        S_WAIT   = 2'd3
    } cpu_state_t;

    cpu_state_t state, state_nx;
    logic       issue;
    logic       acc_we;

    logic [IDX_W-1:0] ram_addr;
    logic             wr_lo, wr_hi;
    logic [7:0]       mem_lo [DEPTH];
    logic [7:0]       mem_hi [DEPTH];
    logic [7:0]       q_lo, q_hi;

    logic        hl_in;
    logic        s1_blank_n, s1_shadow, s1_hl;
    logic [14:0] w_word;
    logic        w_blank_n, w_shadow, w_hl;

`ifdef PAL_HIGHLIGHT_EN
    assign hl_in = pix_highlight;
`else
    assign hl_in = 1'b0;
`endif

    // Expand a 5-bit component to OUT_W bits, then apply blank/shadow/highlight.
    function automatic logic [OUT_W-1:0] shade(input logic [4:0] c, input logic bn,
                                               input logic sh, input logic hl);
        logic [9:0]       rep;
        logic [OUT_W-1:0] e;
        rep = {c, c};
        e   = rep[9 -: OUT_W];
        if (!bn)
            shade = '0;
        else if (sh && hl)
            shade = e;
        else if (sh)
            shade = (SHADOW_MODE == 0) ? (e >> 1) : (e - (e >> 2));
        else if (hl)
            shade = e + ((OUT_MAX - e) >> 1);
        else
            shade = e;
    endfunction

    // Pixel fetch owns the RAM on ce_pix cycles; the CPU only issues otherwise.
    assign ram_addr  = ce_pix ? pix_idx : cpu_addr;
    assign wr_lo     = issue && cpu_we && cpu_be[0];
    assign wr_hi     = issue && cpu_we && cpu_be[1];
    assign cpu_ack   = (state == S_ACK);
    assign cpu_state = state;

    // Low byte bank: write-enable per byte, registered read.
    always_ff @(posedge clk_sys) begin
        if (wr_lo)
            mem_lo[ram_addr] <= cpu_din[7:0];
        q_lo <= mem_lo[ram_addr];
    end

    // High byte bank.
    always_ff @(posedge clk_sys) begin
        if (wr_hi)
            mem_hi[ram_addr] <= cpu_din[15:8];
        q_hi <= mem_hi[ram_addr];
    end

    // CPU FSM next state; the RAM op is issued in the IDLE cycle itself.
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cpu_req && !ce_pix) begin
                    issue    = 1'b1;
                    state_nx = S_ACCESS;
                end
            end
            S_ACCESS: state_nx = S_ACK;
            S_ACK:    state_nx = S_WAIT;
            S_WAIT:   if (!cpu_req) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // CPU FSM state register; reset abandons any access in flight.
    always_ff @(posedge clk_sys) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Remember direction of the issued access and capture read data.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            acc_we   <= 1'b0;
            cpu_dout <= '0;
        end else begin
            if (issue)
                acc_we <= cpu_we;
            if (state == S_ACCESS && !acc_we)
                cpu_dout <= {q_hi, q_lo};
        end
    end

    // Pixel pipeline: flags at ce_pix, word register one cycle later
    // (pix_valid is the delayed ce_pix, so it marks the cycle q holds pixel data).
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pix_valid  <= 1'b0;
            s1_blank_n <= 1'b0;
            s1_shadow  <= 1'b0;
            s1_hl      <= 1'b0;
            w_word     <= '0;
            w_blank_n  <= 1'b0;
            w_shadow   <= 1'b0;
            w_hl       <= 1'b0;
        end else begin
            pix_valid <= ce_pix;
            if (ce_pix) begin
                s1_blank_n <= pix_blank_n;
                s1_shadow  <= pix_shadow;
                s1_hl      <= hl_in;
            end
            if (pix_valid) begin
                w_word    <= {q_hi[6:0], q_lo};
                w_blank_n <= s1_blank_n;
                w_shadow  <= s1_shadow;
                w_hl      <= s1_hl;
            end
        end
    end

    // Colour output registers update on the next pixel enable.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (ce_pix) begin
            red   <= shade(w_word[4:0],   w_blank_n, w_shadow, w_hl);
            green <= shade(w_word[9:5],   w_blank_n, w_shadow, w_hl);
            blue  <= shade(w_word[14:10], w_blank_n, w_shadow, w_hl);
        end
    end

endmodule

// File: tb/tb_palette_lut.sv
// Directed testbench for palette_lut (IDX_W=11, OUT_W=6).
module tb_palette_lut;

    localparam int IDX_W       = 11;
    localparam int OUT_W       = 6;
    localparam int SHADOW_MODE = 0;
    localparam logic [OUT_W-1:0] EXP_SHADOW_22 = (SHADOW_MODE == 0) ? 6'd22 : 6'd34;

    logic             clk_sys = 1'b0;
    logic             reset = 1'b1;
    logic             ce_pix = 1'b0;
    logic [IDX_W-1:0] pix_idx = '0;
    logic             pix_blank_n = 1'b0;
    logic             pix_shadow = 1'b0;
`ifdef PAL_HIGHLIGHT_EN
    logic             pix_highlight = 1'b0;
`endif
    logic             cpu_req = 1'b0;
    logic             cpu_we = 1'b0;
    logic [IDX_W-1:0] cpu_addr = '0;
    logic [1:0]       cpu_be = '0;
    logic [15:0]      cpu_din = '0;
    logic [15:0]      cpu_dout;
    logic             cpu_ack;
    logic [OUT_W-1:0] red, green, blue;
    logic             pix_valid;
    logic [1:0]       cpu_state;

    int checks = 0;
    int errors = 0;

    logic [OUT_W-1:0] obs_r, obs_g, obs_b;
    logic             obs_v, obs_v2;

    palette_lut #(.IDX_W(IDX_W), .OUT_W(OUT_W), .SHADOW_MODE(SHADOW_MODE)) dut (
        .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .pix_idx(pix_idx),
        .pix_blank_n(pix_blank_n), .pix_shadow(pix_shadow),
`ifdef PAL_HIGHLIGHT_EN
        .pix_highlight(pix_highlight),
`endif
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .red(red), .green(green), .blue(blue), .pix_valid(pix_valid),
        .cpu_state(cpu_state)
    );

    // Clock
    always #5 clk_sys = ~clk_sys;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // Present one pixel (ce_pix pulse + one idle cycle). obs_* capture the
    // outputs right after the ce_pix edge, i.e. the previous pixel's colour.
    task automatic send_pix(input logic [IDX_W-1:0] idx, input logic bn, input logic sh);
        ce_pix = 1'b1; pix_idx = idx; pix_blank_n = bn; pix_shadow = sh;
        step();
        obs_r = red; obs_g = green; obs_b = blue; obs_v = pix_valid;
        ce_pix = 1'b0; pix_blank_n = 1'b0; pix_shadow = 1'b0;
        step();
        obs_v2 = pix_valid;
    endtask

    // One CPU access. with_ce raises a pixel enable in the same first cycle.
    // lat = cycles from request to visible ack (-1 on timeout), acks counts
    // every ack seen while req is held, st1 is the FSM state after cycle one.
    task automatic cpu_access(input logic we, input logic [IDX_W-1:0] addr,
                              input logic [1:0] be, input logic [15:0] din,
                              input logic with_ce, input logic [IDX_W-1:0] pidx,
                              output logic [15:0] dout, output int acks,
                              output int lat, output logic [1:0] st1);
        int c;
        acks = 0; lat = -1; dout = '0; c = 1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_din = din;
        if (with_ce) begin
            ce_pix = 1'b1; pix_idx = pidx; pix_blank_n = 1'b1; pix_shadow = 1'b0;
        end
        step();
        st1 = cpu_state;
        ce_pix = 1'b0; pix_blank_n = 1'b0;
        while (lat < 0 && c <= 10) begin
            if (cpu_ack === 1'b1) begin
                lat = c; acks++; dout = cpu_dout;
            end else begin
                step(); c++;
            end
        end
        repeat (4) begin
            step();
            if (cpu_ack === 1'b1) acks++;
        end
        cpu_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++; if (red !== '0 || green !== '0 || blue !== '0) begin errors++; $display("FAIL reset_rgb got %0d/%0d/%0d want 0/0/0", red, green, blue); end
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", cpu_ack); end
        checks++; if (cpu_dout !== 16'h0000) begin errors++; $display("FAIL reset_dout got %h want 0000", cpu_dout); end
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", pix_valid); end
        checks++; if (cpu_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", cpu_state); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_idle_pixels();
        for (int i = 0; i < 3; i++) begin
            send_pix(IDX_W'(i), 1'b0, 1'b0);
            checks++; if ({obs_r, obs_g, obs_b} !== '0) begin errors++; $display("FAIL idle_rgb[%0d] got %0d/%0d/%0d want 0/0/0", i, obs_r, obs_g, obs_b); end
            checks++; if (obs_v !== 1'b1) begin errors++; $display("FAIL idle_valid_pulse[%0d] got %b want 1", i, obs_v); end
            checks++; if (obs_v2 !== 1'b0) begin errors++; $display("FAIL idle_valid_low[%0d] got %b want 0", i, obs_v2); end
            checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL idle_ack[%0d] got %b want 0", i, cpu_ack); end
        end
    endtask

    task automatic test_cpu_rw();
        logic [15:0] d; int a, l; logic [1:0] s;
        cpu_access(1'b1, 11'h005, 2'b11, 16'h5AD6, 1'b0, '0, d, a, l, s);
        checks++; if (a !== 1) begin errors++; $display("FAIL wr_acks got %0d want 1", a); end
        checks++; if (l !== 2) begin errors++; $display("FAIL wr_latency got %0d want 2", l); end
        checks++; if (s !== 2'd1) begin errors++; $display("FAIL wr_state_access got %0d want 1", s); end
        cpu_access(1'b0, 11'h005, 2'b11, 16'h0000, 1'b0, '0, d, a, l, s);
        checks++; if (d !== 16'h5AD6) begin errors++; $display("FAIL rd_full got %h want 5ad6", d); end
        checks++; if (a !== 1) begin errors++; $display("FAIL rd_acks_held_req got %0d want 1", a); end
        cpu_access(1'b1, 11'h005, 2'b01, 16'hFFFF, 1'b0, '0, d, a, l, s);
        cpu_access(1'b0, 11'h005, 2'b11, 16'h0000, 1'b0, '0, d, a, l, s);
        checks++; if (d !== 16'h5AFF) begin errors++; $display("FAIL rd_be01 got %h want 5aff", d); end
        cpu_access(1'b1, 11'h005, 2'b00, 16'h1234, 1'b0, '0, d, a, l, s);
        checks++; if (a !== 1) begin errors++; $display("FAIL wr_be00_ack got %0d want 1", a); end
        cpu_access(1'b0, 11'h005, 2'b11, 16'h0000, 1'b0, '0, d, a, l, s);
        checks++; if (d !== 16'h5AFF) begin errors++; $display("FAIL rd_after_be00 got %h want 5aff", d); end
        // restore low byte, and load a word with distinct components and bit 15 set
        cpu_access(1'b1, 11'h005, 2'b01, 16'h00D6, 1'b0, '0, d, a, l, s);
        cpu_access(1'b1, 11'h010, 2'b11, 16'hFE01, 1'b0, '0, d, a, l, s);
        cpu_access(1'b0, 11'h010, 2'b11, 16'h0000, 1'b0, '0, d, a, l, s);
        checks++; if (d !== 16'hFE01) begin errors++; $display("FAIL rd_bit15 got %h want fe01", d); end
    endtask

    task automatic test_pixel_colour();
        send_pix(11'h005, 1'b1, 1'b0);
        send_pix(11'h005, 1'b1, 1'b1);
        checks++; if ({obs_r, obs_g, obs_b} !== {6'd45, 6'd45, 6'd45}) begin errors++; $display("FAIL pix_plain got %0d/%0d/%0d want 45/45/45", obs_r, obs_g, obs_b); end
        send_pix(11'h005, 1'b0, 1'b0);
        checks++; if ({obs_r, obs_g, obs_b} !== {3{EXP_SHADOW_22}}) begin errors++; $display("FAIL pix_shadow got %0d/%0d/%0d want %0d", obs_r, obs_g, obs_b, EXP_SHADOW_22); end
        send_pix(11'h010, 1'b1, 1'b0);
        checks++; if ({obs_r, obs_g, obs_b} !== '0) begin errors++; $display("FAIL pix_blank got %0d/%0d/%0d want 0/0/0", obs_r, obs_g, obs_b); end
        send_pix(11'h000, 1'b0, 1'b0);
        checks++; if ({obs_r, obs_g, obs_b} !== {6'd2, 6'd33, 6'd63}) begin errors++; $display("FAIL pix_components got %0d/%0d/%0d want 2/33/63", obs_r, obs_g, obs_b); end
    endtask

    task automatic test_stall();
        logic [15:0] d; int a, l; logic [1:0] s;
        cpu_access(1'b0, 11'h005, 2'b11, 16'h0000, 1'b1, 11'h010, d, a, l, s);
        checks++; if (s !== 2'd0) begin errors++; $display("FAIL stall_state got %0d want 0", s); end
        checks++; if (l !== 3) begin errors++; $display("FAIL stall_latency got %0d want 3", l); end
        checks++; if (d !== 16'h5AD6) begin errors++; $display("FAIL stall_rd got %h want 5ad6", d); end
        send_pix(11'h000, 1'b0, 1'b0);
        checks++; if ({obs_r, obs_g, obs_b} !== {6'd2, 6'd33, 6'd63}) begin errors++; $display("FAIL stall_pixel got %0d/%0d/%0d want 2/33/63", obs_r, obs_g, obs_b); end
    endtask

    task automatic test_write_then_pixel();
        logic [15:0] d; int a, l; logic [1:0] s;
        cpu_access(1'b1, 11'h020, 2'b11, 16'h0421, 1'b0, '0, d, a, l, s);
        send_pix(11'h020, 1'b1, 1'b0);
        send_pix(11'h000, 1'b0, 1'b0);
        checks++; if ({obs_r, obs_g, obs_b} !== {6'd2, 6'd2, 6'd2}) begin errors++; $display("FAIL wr_then_pix got %0d/%0d/%0d want 2/2/2", obs_r, obs_g, obs_b); end
    endtask

    task automatic test_reset_mid_access();
        int extra;
        extra = 0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h030; cpu_be = 2'b11; cpu_din = 16'hBEEF;
        step();
        checks++; if (cpu_state !== 2'd1) begin errors++; $display("FAIL mid_in_access got %0d want 1", cpu_state); end
        reset = 1'b1;
        step();
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL mid_reset_ack got %b want 0", cpu_ack); end
        checks++; if (cpu_state !== 2'd0) begin errors++; $display("FAIL mid_reset_state got %0d want 0", cpu_state); end
        reset = 1'b0; cpu_req = 1'b0;
        repeat (4) begin
            step();
            if (cpu_ack === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL mid_reset_late_ack got %0d want 0", extra); end
    endtask

`ifdef PAL_HIGHLIGHT_EN
    task automatic test_highlight();
        pix_highlight = 1'b1;
        send_pix(11'h005, 1'b1, 1'b0);
        send_pix(11'h005, 1'b1, 1'b1);
        checks++; if ({obs_r, obs_g, obs_b} !== {6'd54, 6'd54, 6'd54}) begin errors++; $display("FAIL hl_only got %0d/%0d/%0d want 54", obs_r, obs_g, obs_b); end
        pix_highlight = 1'b0;
        send_pix(11'h000, 1'b0, 1'b0);
        checks++; if ({obs_r, obs_g, obs_b} !== {6'd45, 6'd45, 6'd45}) begin errors++; $display("FAIL hl_shadow_cancel got %0d/%0d/%0d want 45", obs_r, obs_g, obs_b); end
    endtask
`endif

    initial begin
        test_reset();
        test_idle_pixels();
        test_cpu_rw();
        test_pixel_colour();
        test_stall();
        test_write_then_pixel();
        test_reset_mid_access();
`ifdef PAL_HIGHLIGHT_EN
        test_highlight();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
